mul32_seq: RTL
==============

Name: mul32_seq

Overview:
- Iterative 32-bit integer multiplier for the execute stage. It is the additive counterpart to the subtract path: radix-2 shift-and-add, one partial product per cycle.
- Implements the RV32M multiply group: MUL, MULH, MULHSU and MULHU.
- Uses a start/busy/done handshake toward the pipeline control, which stalls while busy is high.

Parameters:
- XLEN, 32, operand and result width. Only 32 is supported.
- CNT_W, 6, width of the iteration counter. Must hold XLEN.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse, sampled only in IDLE.
- op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- rs1  input  32  multiplicand, captured when start is accepted.
- rs2  input  32  multiplier, captured when start is accepted.
- busy  output  1  high from the start-accept edge until done deasserts.
- done  output  1  one-cycle completion pulse.
- rd  output  32  result. Holds its value until the next completion.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, busy=0, done=0, rd=0, all internal registers 0.
- Reset mid-operation: the current operation is aborted at once. No done is produced, and the next start is handled normally.
- States:
  - IDLE: if start=1, capture operands and op, set busy=1, load cnt=0, go to CALC.
  - CALC: one iteration per edge, cnt++. Go to FIX on the edge where cnt reaches 31→32, so there are exactly 32 CALC edges.
  - FIX: apply sign correction, select the result half, load rd, set done=1. Go to DONE.
  - DONE: done=0, busy=0, go to IDLE. start is not accepted in this state.
- Latency: start is sampled at edge E0. CALC runs over E1..E32, FIX at E33, so done is high between E33 and E34, and rd is valid from E33. The earliest next accept is E35.
- start while busy is ignored. Operand changes after the accept edge have no effect.
- Signedness: rs1 is signed for MULH and MULHSU. rs2 is signed only for MULH. MUL uses the low word, which is sign-independent.
- Operands are converted to magnitudes at accept. The result sign is the XOR of the operand signs, considering only operands treated as signed.
- The 64-bit magnitude product is two's-complement negated in FIX when the result sign is 1.
- rd is product[31:0] for MUL and product[63:32] otherwise.
- Corner values:
  - 0x80000000 magnitude: the 32-bit unsigned magnitude must handle it with no overflow.
  - Zero operands give 0, with no negative-zero artefact.
- busy and done are never both low while in CALC or FIX.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- When defined: in CALC, if the remaining right-shifted multiplier magnitude is 0 after the current iteration, the next state is FIX regardless of cnt. Latency becomes (index of the highest set bit of |rs2|) + 1 CALC edges, with a minimum of 1 when |rs2|=0. Results are bit-identical to the default build.
- When undefined: fixed 32 CALC edges. No extra comparator is synthesized.

Test Plan:
- Reset, then MUL with rs1=7, rs2=6, start at E0 -> busy=1 from E0, done pulse for exactly one cycle after E33, rd=0x0000002A, busy=0 after E34.
- MULH with rs1=rs2=0x80000000 -> rd=0x40000000. MUL with the same operands -> rd=0x00000000.
- MULHSU with rs1=rs2=0xFFFFFFFF -> rd=0xFFFFFFFF. MULHU with the same operands -> rd=0xFFFFFFFE. MUL with the same operands -> rd=0x00000001.
- MUL with rs1=3, rs2=5, then pulse start at E10 with rs1=9, rs2=9 -> second request ignored, rd=0x0000000F after E33, only one done pulse.
- Start MULHU with rs1=rs2=0xFFFFFFFF, assert rst_n=0 asynchronously mid-cycle after E10 -> busy, done and rd go to 0 immediately. Release reset, then MUL with rs1=-2 (0xFFFFFFFE), rs2=3 -> rd=0xFFFFFFFA.
- With MUL_EARLY_TERM_EN:
  - MUL with rs1=5, rs2=3 -> done after E3, rd=0x0000000F.
  - rs2=0 -> done after E2, rd=0.
  - MULH with rs1=rs2=0x80000000 -> done after E33, rd=0x40000000.

Source files
------------

// File: rtl/mul32_seq.sv
// Iterative radix-2 shift-and-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU group.
// Optional early termination on an exhausted multiplier is enabled by defining MUL_EARLY_TERM_EN.
module mul32_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] rd
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_t              state;
    state_t              state_nxt;
    logic [2*XLEN-1:0]   mcand;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     mplier;
    logic [CNT_W-1:0]    cnt;
    logic                neg;
    logic                hi_sel;
    logic                rs1_signed;
    logic                rs2_signed;

    // The unsigned result is wide enough for the magnitude of the most negative value.
    function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v,
                                                   input logic is_signed);
        if (is_signed && v < 0)
            return XLEN'(-v);
        return XLEN'(v);
    endfunction

    function automatic logic [2*XLEN-1:0] apply_sign(input logic [2*XLEN-1:0] p,
                                                      input logic n);
        if (n)
            return ~p + {{(2*XLEN-1){1'b0}}, 1'b1};
        return p;
    endfunction

    function automatic logic [XLEN-1:0] select_half(input logic [2*XLEN-1:0] p,
                                                     input logic hi);
        return hi ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
    endfunction

    assign rs1_signed = (op == 2'b01) || (op == 2'b10);
    assign rs2_signed = (op == 2'b01);

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nxt = S_CALC;
            end
            S_CALC: begin
`ifdef MUL_EARLY_TERM_EN
                if (cnt == CNT_LAST || mplier[XLEN-1:1] == '0)
                    state_nxt = S_FIX;
`else
                if (cnt == CNT_LAST)
                    state_nxt = S_FIX;
`endif
            end
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operands become magnitudes at accept; the sign is reapplied once, on the full product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            hi_sel <= 1'b0;
            rd     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= {{XLEN{1'b0}}, magnitude($signed(rs1), rs1_signed)};
                        mplier <= magnitude($signed(rs2), rs2_signed);
                        acc    <= '0;
                        cnt    <= '0;
                        neg    <= (rs1_signed & rs1[XLEN-1]) ^ (rs2_signed & rs2[XLEN-1]);
                        hi_sel <= (op != 2'b00);
                    end
                end
                S_CALC: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                end
                S_FIX: begin
                    rd <= select_half(apply_sign(acc, neg), hi_sel);
                end
                default: ;
            endcase
        end
    end

endmodule
